// File: rtl/cfu.sv
// Custom Function Unit: 32-bit scalar ALU plus 4-lane signed int8 MAC with a
// persistent accumulator, one outstanding command, result registered at output.
module cfu (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  typedef enum logic {IDLE, RESP} state_e;

  localparam logic [2:0] F3_ALU = 3'b111;
  localparam logic [2:0] F3_MAC = 3'b000;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] out_q, out_d;
  logic [31:0] result;
  logic [31:0] acc_upd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign funct3 = cmd_payload_function_id[2:0];
  assign funct7 = cmd_payload_function_id[9:3];

  // Lanes are sign-extended to 16 bits; each product then fits exactly in 16 bits.
  function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] sum;
    logic [15:0] la, lb, prod;
    sum = '0;
    for (int k = 0; k < 4; k++) begin
      la   = {{8{a[8*k+7]}}, a[8*k +: 8]};
      lb   = {{8{b[8*k+7]}}, b[8*k +: 8]};
      prod = la * lb;
      sum  = sum + {{16{prod[15]}}, prod};
    end
    return sum;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    result  = '0;
    acc_upd = acc_q;
    case (funct3)
      F3_ALU: begin
        case (funct7)
          7'd0:    result = cmd_payload_inputs_0 + cmd_payload_inputs_1;
          7'd1:    result = cmd_payload_inputs_0 - cmd_payload_inputs_1;
          7'd2:    result = cmd_payload_inputs_0 * cmd_payload_inputs_1;
          default: result = '0;
        endcase
      end
      F3_MAC: begin
        case (funct7)
          7'd0: begin
            acc_upd = acc_q + dot4(cmd_payload_inputs_0, cmd_payload_inputs_1);
            result  = acc_upd;
          end
          7'd1: begin
            acc_upd = '0;
            result  = '0;
          end
          default: result = acc_q;
        endcase
      end
      default: result = '0;
    endcase
  end

  // Commands are only looked at in IDLE, so a held cmd_valid cannot re-execute.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = RESP;
          acc_d   = acc_upd;
          out_d   = result;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all update together.
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  assign rsp_valid             = (state_q == RESP);
  assign cmd_ready             = (state_q == IDLE);
  assign rsp_payload_outputs_0 = out_q;

endmodule

// File: tb/tb_cfu.sv
// Self-checking bench for cfu: directed scenarios plus randomized commands
// compared against an arithmetic reference model of the instruction set.
module tb_cfu;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  int checks   = 0;
  int failures = 0;
  logic [31:0] acc_m;

  cfu dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0)
  );

  always #5 clk = ~clk;

  // Reference model: executes one instruction, updating the model accumulator.
  task automatic model_exec(input logic [9:0] fid, input logic [31:0] a,
                            input logic [31:0] b, output logic [31:0] r);
    int  dot;
    byte sa, sb;
    r = 32'd0;
    if (fid[2:0] == 3'b111) begin
      case (int'(fid[9:3]))
        0: r = a + b;
        1: r = a - b;
        2: r = a * b;
        default: r = 32'd0;
      endcase
    end else if (fid[2:0] == 3'b000) begin
      dot = 0;
      for (int k = 0; k < 4; k++) begin
        sa  = a[8*k +: 8];
        sb  = b[8*k +: 8];
        dot = dot + int'(sa) * int'(sb);
      end
      case (int'(fid[9:3]))
        0: begin acc_m = acc_m + dot; r = acc_m; end
        1: begin acc_m = 32'd0; r = 32'd0; end
        default: r = acc_m;
      endcase
    end
  endtask

  // Issue one command, wait for the response, check it, then consume it.
  task automatic do_cmd(input string name, input logic [9:0] fid,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int n;
    cmd_valid = 1'b1;
    cmd_payload_function_id = fid;
    cmd_payload_inputs_0 = a;
    cmd_payload_inputs_1 = b;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!rsp_valid && n < 20);
    cmd_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s rsp_valid timeout: got %b want 1", name, rsp_valid);
    end
    checks++;
    if (rsp_payload_outputs_0 !== exp) begin
      failures++;
      $display("FAIL %s result: got %h want %h", name, rsp_payload_outputs_0, exp);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s drop: got valid=%b ready=%b want 0/1", name, rsp_valid, cmd_ready);
    end
    checks++;
    if (rsp_payload_outputs_0 !== exp) begin
      failures++;
      $display("FAIL %s hold_after_drop: got %h want %h", name, rsp_payload_outputs_0, exp);
    end
  endtask

  task automatic run_model(input string name, input logic [9:0] fid,
                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    model_exec(fid, a, b, r);
    do_cmd(name, fid, a, b, r);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    acc_m = 32'd0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_payload_outputs_0 !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: got valid=%b ready=%b out=%h want 0/1/0",
               rsp_valid, cmd_ready, rsp_payload_outputs_0);
    end
  endtask

  task automatic test_alu();
    run_model("alu_add", 10'h007, 32'd5, 32'd3);
    do_cmd("alu_add_const", 10'h007, 32'd5, 32'd3, 32'd8);
    do_cmd("alu_sub", 10'h00F, 32'd5, 32'd3, 32'd2);
    do_cmd("alu_mul", 10'h017, 32'd5, 32'd3, 32'd15);
    do_cmd("alu_sub_wrap", 10'h00F, 32'd3, 32'd5, 32'hFFFF_FFFE);
    do_cmd("alu_mul_wrap", 10'h017, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    do_cmd("alu_unknown_f7", 10'h01F, 32'd5, 32'd3, 32'd0);
  endtask

  task automatic test_mac();
    do_cmd("mac_clear0", 10'h008, 32'd0, 32'd0, 32'd0);
    do_cmd("mac_acc1", 10'h000, 32'h0000_0505, 32'h0000_0403, 32'd35);
    do_cmd("mac_acc2", 10'h000, 32'h0000_0505, 32'h0000_0403, 32'd70);
    do_cmd("mac_read", 10'h010, 32'h1234_5678, 32'h9ABC_DEF0, 32'd70);
    do_cmd("alu_keeps_acc", 10'h007, 32'd1, 32'd1, 32'd2);
    do_cmd("mac_read2", 10'h018, 32'd0, 32'd0, 32'd70);
    do_cmd("mac_clear", 10'h008, 32'h0000_0505, 32'h0000_0403, 32'd0);
    do_cmd("mac_acc3", 10'h000, 32'h0000_0505, 32'h0000_0403, 32'd35);
    acc_m = 32'd35;
  endtask

  task automatic test_signed();
    do_cmd("sgn_clear", 10'h008, 32'd0, 32'd0, 32'd0);
    do_cmd("sgn_lanes", 10'h000, 32'hFF80_7F01, 32'h0280_7F01, 32'h0000_7F00);
    acc_m = 32'h0000_7F00;
  endtask

  task automatic test_handshake();
    do_cmd("hs_clear", 10'h008, 32'd0, 32'd0, 32'd0);
    cmd_valid = 1'b1;
    cmd_payload_function_id = 10'h000;
    cmd_payload_inputs_0 = 32'h0000_0505;
    cmd_payload_inputs_1 = 32'h0000_0403;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_payload_outputs_0 !== 32'd35) begin
        failures++;
        $display("FAIL hs_hold cycle %0d: got valid=%b ready=%b out=%h want 1/0/00000023",
                 i, rsp_valid, cmd_ready, rsp_payload_outputs_0);
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_payload_outputs_0 !== 32'd35) begin
      failures++;
      $display("FAIL hs_drop: got valid=%b out=%h want 0/00000023", rsp_valid, rsp_payload_outputs_0);
    end
    do_cmd("hs_next_acc", 10'h000, 32'h0000_0505, 32'h0000_0403, 32'd70);
    acc_m = 32'd70;
    // rsp_ready with nothing pending must change nothing.
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_payload_outputs_0 !== 32'd70) begin
      failures++;
      $display("FAIL hs_idle_ready: got valid=%b ready=%b out=%h want 0/1/00000046",
               rsp_valid, cmd_ready, rsp_payload_outputs_0);
    end
    do_cmd("hs_acc_check", 10'h010, 32'd0, 32'd0, 32'd70);
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1;
    cmd_payload_function_id = 10'h000;
    cmd_payload_inputs_0 = 32'h0101_0101;
    cmd_payload_inputs_1 = 32'h0101_0101;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rm_pending: got valid=%b want 1", rsp_valid);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    acc_m = 32'd0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_payload_outputs_0 !== 32'd0) begin
      failures++;
      $display("FAIL rm_reset: got valid=%b ready=%b out=%h want 0/1/0",
               rsp_valid, cmd_ready, rsp_payload_outputs_0);
    end
    do_cmd("rm_acc_zero", 10'h010, 32'd7, 32'd9, 32'd0);
    do_cmd("unknown_f3", 10'h003, 32'd5, 32'd3, 32'd0);
  endtask

  task automatic test_random();
    logic [9:0] fid;
    logic [2:0] f3;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0, 1: f3 = 3'b000;
        2:    f3 = 3'b111;
        default: f3 = 3'($urandom_range(1, 6));
      endcase
      fid = {7'($urandom_range(0, 3)), f3};
      // Keep CLEAR rare so the accumulator builds up and wraps.
      if (f3 == 3'b000 && fid[9:3] == 7'd1 && $urandom_range(0, 3) != 0)
        fid[9:3] = 7'd0;
      run_model($sformatf("rand%0d_fid%h", i, fid), fid, $urandom, $urandom);
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0 = '0;
    cmd_payload_inputs_1 = '0;
    acc_m = 32'd0;
    test_reset();
    test_alu();
    test_mac();
    test_signed();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
